// File: rtl/sim_host_dev.sv
// rtl/sim_host_dev.sv - simulation host device: exit latch, console FIFO, 64-bit cycle counter
// Optional watchdog built when SIM_HOST_WATCHDOG_EN is defined.
module sim_host_dev #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] BASE_ADR    = '0,
   parameter int unsigned     CON_DEPTH   = 16,
   parameter int unsigned     WDOG_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            r_v,
   input  logic            w_v,
   input  logic [XLEN-1:0] adr,
   input  logic [XLEN-1:0] data,
   input  logic [3:0]      strobe,
   output logic [XLEN-1:0] resp,
   output logic            resp_valid,
   output logic            done,
   output logic [XLEN-1:0] exit_code,
   output logic            timeout,
   output logic            con_v,
   output logic [7:0]      con_data,
   input  logic            con_rdy
);

   localparam int unsigned PW = $clog2(CON_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic            resp_valid_q, done_q, timeout_q, ovf_q;
   logic [XLEN-1:0] resp_q, exit_q;
   logic [63:0]     cyc_q, cyc_d;
   logic [31:0]     shadow_q;
   logic [PW-1:0]   wp_q, rp_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      mem_q [CON_DEPTH];

   logic            hit, wr, rd, push, pop, push_ok, exit_wr, expire;
   logic [2:0]      sel;
   logic [15:0]     free_slots;
   logic [XLEN-1:0] rdata;

   always_comb begin
      hit        = adr[XLEN-1:5] == BASE_ADR[XLEN-1:5];
      sel        = adr[4:2];
      wr         = hit && w_v;
      rd         = hit && r_v && !w_v;
      exit_wr    = wr && (sel == 3'd0) && !done_q;
      push       = wr && (sel == 3'd1) && strobe[0];
      pop        = (cnt_q != '0) && con_rdy;
      // A pop frees the slot the same-cycle push lands in, so a full FIFO still accepts.
      push_ok    = push && ((cnt_q != CW'(CON_DEPTH)) || pop);
      cnt_d      = cnt_q + CW'(push_ok) - CW'(pop);
      cyc_d      = done_q ? cyc_q : cyc_q + 64'd1;
      free_slots = 16'(CW'(CON_DEPTH) - cnt_q);
      rdata      = '0;
      case (sel)
         3'd1:    rdata = XLEN'({ovf_q, 15'b0, free_slots});
         3'd2:    rdata = XLEN'(cyc_q[31:0]);
         3'd3:    rdata = XLEN'(shadow_q);
         default: rdata = '0;
      endcase
   end

`ifdef SIM_HOST_WATCHDOG_EN
   logic [31:0] wdog_q;
   logic        kick;

   assign kick   = wr && (sel == 3'd4);
   assign expire = !done_q && (wdog_q == WDOG_CYCLES);

   always_ff @(posedge clk) begin
      if (rst)          wdog_q <= '0;
      else if (kick)    wdog_q <= '0;
      else if (!done_q) wdog_q <= wdog_q + 32'd1;
   end
`else
   logic unused_wdog;
   assign expire      = 1'b0;
   assign unused_wdog = ^WDOG_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
         done_q       <= 1'b0;
         exit_q       <= '0;
         timeout_q    <= 1'b0;
         ovf_q        <= 1'b0;
         cyc_q        <= '0;
         shadow_q     <= '0;
         wp_q         <= '0;
         rp_q         <= '0;
         cnt_q        <= '0;
      end else begin
         resp_valid_q <= hit && (r_v || w_v);
         resp_q       <= rd ? rdata : '0;
         cyc_q        <= cyc_d;
         cnt_q        <= cnt_d;
         if (exit_wr) begin
            done_q <= 1'b1;
            exit_q <= data;
         end else if (expire) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            exit_q    <= XLEN'(32'hDEAD_0001);
         end
         if (rd && (sel == 3'd2)) shadow_q <= cyc_q[63:32];
         if (push && !push_ok)    ovf_q    <= 1'b1;
         if (push_ok)             wp_q     <= wp_q + 1'b1;
         if (pop)                 rp_q     <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wp_q] <= data[7:0];
   end

   logic unused_bits;
   assign unused_bits = ^{adr[1:0], strobe[3:1]};

   assign resp       = resp_q;
   assign resp_valid = resp_valid_q;
   assign done       = done_q;
   assign exit_code  = exit_q;
   assign timeout    = timeout_q;
   assign con_v      = cnt_q != '0;
   assign con_data   = con_v ? mem_q[rp_q] : 8'h00;

endmodule
